// File: rtl/mem_stage_if.sv
// mem_stage_if: data-bus request/ready bundle between the MEM stage (master) and data memory (slave).
// Latency: none; wires only.
// Backpressure: slave holds dbus_ready low to extend a transaction; master keeps the request stable meanwhile.
interface mem_stage_if;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_rdata;
  logic        dbus_ready;

  modport master (
    output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    input  dbus_rdata, dbus_ready
  );

  modport slave (
    input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_be,
    output dbus_rdata, dbus_ready
  );
endinterface

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage; turns EX load/store control into a data-bus access and fills the MEM->WB register.
// Latency: 1 cycle for non-memory ops; loads/stores take an IDLE cycle plus BUSY cycles until dbus_ready (min 2).
// Backpressure: stall_MEM freezes upstream while an access is pending; BUS_TIMEOUT (0 = off) aborts a hung bus.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned H/W accesses instead of truncating the address.
module mem_stage #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regwrite_EX,
  input  logic        datawe_EX,
  input  logic [2:0]  wbsel_EX,
  input  logic [2:0]  strb_EX,
  input  logic [4:0]  rd_EX,
  input  logic [31:0] aluout_EX,
  input  logic [31:0] rdata2_EX,
  input  logic [31:0] immext_EX,
  input  logic [31:0] pcimmaui_EX,
  input  logic [31:0] pcnext_EX,
  mem_stage_if.master dbus,
  output logic        stall_MEM,
  output logic        regwrite_MEM,
  output logic [2:0]  wbsel_MEM,
  output logic [4:0]  rd_MEM,
  output logic [31:0] aluout_MEM,
  output logic [31:0] rdata_MEM,
  output logic [31:0] immext_MEM,
  output logic [31:0] pcimmaui_MEM,
  output logic [31:0] pcnext_MEM,
  output logic        buserr_MEM,
  output logic        misalign_MEM
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  typedef struct packed {
    logic        regwrite;
    logic [2:0]  wbsel;
    logic [4:0]  rd;
    logic [31:0] aluout;
    logic [31:0] rdata;
    logic [31:0] immext;
    logic [31:0] pcimmaui;
    logic [31:0] pcnext;
  } wb_t;

  localparam int unsigned CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BUS_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  wb_t           wb_q, wb_d;
  logic          buserr_q, buserr_d;
  logic          misal_q, misal_d;

  logic        is_load, access, sz_b, sz_h, trap_c, timeout_c, req_c;
  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_c, wdata_c;
  logic [3:0]  be_c;

  assign is_load = (wbsel_EX == 3'b001);
  assign access  = datawe_EX | is_load;
  assign off     = aluout_EX[1:0];
  // Size from funct3 low bits; bit 2 only selects zero-extension. Unlisted codes fall to word.
  assign sz_b    = (strb_EX[1:0] == 2'b00);
  assign sz_h    = (strb_EX[1:0] == 2'b01);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_c = access & ((sz_h & off[0]) | (~sz_b & ~sz_h & (off != 2'b00)));
`else
  assign trap_c = 1'b0;
`endif

  assign req_c     = (state_q == BUSY);
  assign timeout_c = (BUS_TIMEOUT != 0) && (cnt_q == CNT_LAST) && !dbus.dbus_ready;

  assign ld_byte = dbus.dbus_rdata[{off, 3'b000} +: 8];
  assign ld_half = dbus.dbus_rdata[{off[1], 4'b0000} +: 16];

  // Store lane steering: replicate data across the word, enable only the addressed lanes.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = rdata2_EX;
    if (datawe_EX) begin
      if (sz_b) begin
        wdata_c = {4{rdata2_EX[7:0]}};
        be_c    = 4'b0001 << off;
      end else if (sz_h) begin
        wdata_c = {2{rdata2_EX[15:0]}};
        be_c    = 4'b0011 << {off[1], 1'b0};
      end
    end
  end

  // Load alignment and sign/zero extension of the returned word.
  always_comb begin
    load_c = dbus.dbus_rdata;
    if (sz_b) begin
      load_c = strb_EX[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (sz_h) begin
      load_c = strb_EX[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end
  end

  // Next-state, stall and WB-register control; WB is a bubble unless an instruction retires this cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buserr_d  = 1'b0;
    misal_d   = 1'b0;
    stall_MEM = 1'b0;
    wb_d      = '{regwrite: 1'b0, wbsel: wbsel_EX, rd: rd_EX, aluout: aluout_EX, rdata: 32'd0,
                  immext: immext_EX, pcimmaui: pcimmaui_EX, pcnext: pcnext_EX};
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (trap_c) begin
          misal_d = 1'b1;
        end else if (access) begin
          stall_MEM = 1'b1;
          state_d   = BUSY;
        end else begin
          wb_d.regwrite = regwrite_EX;
        end
      end
      BUSY: begin
        if (dbus.dbus_ready) begin
          wb_d.regwrite = regwrite_EX;
          wb_d.rdata    = is_load ? load_c : 32'd0;
          state_d       = IDLE;
          cnt_d         = '0;
        end else if (timeout_c) begin
          buserr_d = 1'b1;
          state_d  = IDLE;
          cnt_d    = '0;
        end else begin
          stall_MEM = 1'b1;
          cnt_d     = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // All stage state; async reset drops the request and clears the WB register at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wb_q     <= '0;
      buserr_q <= 1'b0;
      misal_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wb_q     <= wb_d;
      buserr_q <= buserr_d;
      misal_q  <= misal_d;
    end
  end

  assign dbus.dbus_req   = req_c;
  assign dbus.dbus_we    = req_c & datawe_EX;
  assign dbus.dbus_addr  = {aluout_EX[31:2], 2'b00};
  assign dbus.dbus_wdata = wdata_c;
  assign dbus.dbus_be    = be_c;

  assign regwrite_MEM = wb_q.regwrite;
  assign wbsel_MEM    = wb_q.wbsel;
  assign rd_MEM       = wb_q.rd;
  assign aluout_MEM   = wb_q.aluout;
  assign rdata_MEM    = wb_q.rdata;
  assign immext_MEM   = wb_q.immext;
  assign pcimmaui_MEM = wb_q.pcimmaui;
  assign pcnext_MEM   = wb_q.pcnext;
  assign buserr_MEM   = buserr_q;
  assign misalign_MEM = misal_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage with a byte-level reference model.
// Latency: expected WB events and bus requests are queued at issue and checked when the DUT presents them.
// Backpressure: a bus responder process returns dbus_ready after a per-access latency chosen by the driver.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk, rst;
  logic        regwrite_EX, datawe_EX;
  logic [2:0]  wbsel_EX, strb_EX;
  logic [4:0]  rd_EX;
  logic [31:0] aluout_EX, rdata2_EX, immext_EX, pcimmaui_EX, pcnext_EX;
  logic        stall_MEM, regwrite_MEM, buserr_MEM, misalign_MEM;
  logic [2:0]  wbsel_MEM;
  logic [4:0]  rd_MEM;
  logic [31:0] aluout_MEM, rdata_MEM, immext_MEM, pcimmaui_MEM, pcnext_MEM;

  mem_stage_if dbus_if();

  mem_stage #(.BUS_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .regwrite_EX(regwrite_EX), .datawe_EX(datawe_EX), .wbsel_EX(wbsel_EX), .strb_EX(strb_EX),
    .rd_EX(rd_EX), .aluout_EX(aluout_EX), .rdata2_EX(rdata2_EX), .immext_EX(immext_EX),
    .pcimmaui_EX(pcimmaui_EX), .pcnext_EX(pcnext_EX),
    .dbus(dbus_if),
    .stall_MEM(stall_MEM), .regwrite_MEM(regwrite_MEM), .wbsel_MEM(wbsel_MEM), .rd_MEM(rd_MEM),
    .aluout_MEM(aluout_MEM), .rdata_MEM(rdata_MEM), .immext_MEM(immext_MEM),
    .pcimmaui_MEM(pcimmaui_MEM), .pcnext_MEM(pcnext_MEM),
    .buserr_MEM(buserr_MEM), .misalign_MEM(misalign_MEM)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    logic [31:0] rdata;
  } bus_exp_t;

  typedef struct {
    logic        regwrite;
    logic [2:0]  wbsel;
    logic [4:0]  rd;
    logic [31:0] aluout, rdata, immext, pcimmaui, pcnext;
    bit          chk_rdata;
    bit          buserr;
    bit          misal;
  } wb_exp_t;

  bus_exp_t bus_q[$];
  wb_exp_t  wb_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] strb_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
  logic [2:0] alu_wb   [4] = '{3'b000, 3'b010, 3'b011, 3'b100};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] s);
    case (s)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  // Assemble sz bytes starting at byte eoff of the word, then extend arithmetically.
  function automatic logic [31:0] load_value(input logic [31:0] word, input int eoff, input int sz, input bit sgn);
    longint v;
    v = 0;
    for (int i = 0; i < sz; i++) v += longint'(word[8*(eoff+i) +: 8]) << (8*i);
    if (sgn && sz < 4 && v >= (longint'(1) << (8*sz-1))) v = v - (longint'(1) << (8*sz));
    return v[31:0];
  endfunction

  task automatic issue(input logic rw, input logic we, input logic [2:0] wbs, input logic [2:0] sb,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] d2,
                       input int lat, input logic [31:0] rdat);
    bus_exp_t b;
    wb_exp_t  w;
    int sz, off, eoff, exp_st, st;
    bit acc, ld, trap, first;
    regwrite_EX = rw; datawe_EX = we; wbsel_EX = wbs; strb_EX = sb; rd_EX = rd;
    aluout_EX = alu; rdata2_EX = d2;
    immext_EX = $urandom; pcimmaui_EX = $urandom; pcnext_EX = $urandom;
    ld   = (wbs == 3'b001);
    acc  = we || ld;
    sz   = size_of(sb);
    off  = int'(alu[1:0]);
    eoff = off - (off % sz);
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = acc && ((off % sz) != 0);
`endif
    w.wbsel = wbs; w.rd = rd; w.aluout = alu;
    w.immext = immext_EX; w.pcimmaui = pcimmaui_EX; w.pcnext = pcnext_EX;
    w.misal     = trap;
    w.buserr    = acc && !trap && (lat >= TO);
    w.regwrite  = rw && !trap && !w.buserr;
    w.chk_rdata = ld;
    w.rdata     = load_value(rdat, eoff, sz, !sb[2]);
    if (w.regwrite || w.buserr || w.misal) wb_q.push_back(w);
    if (acc && !trap) begin
      b.we = we; b.addr = {alu[31:2], 2'b00}; b.lat = lat; b.rdata = rdat;
      b.be = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (i >= eoff && i < eoff + sz) b.be[i] = 1'b1;
        b.wdata[8*i +: 8] = d2[8*(i % sz) +: 8];
      end
      if (!we) b.be = 4'b1111;
      bus_q.push_back(b);
    end
    exp_st = (!acc || trap) ? 0 : ((lat >= TO) ? TO : 1 + lat);
    st = 0;
    first = 1'b1;
    forever begin
      @(negedge clk); #1;
      if (first && (!acc || trap)) chk("req_low_no_access", {31'd0, dbus_if.dbus_req}, 32'd0);
      first = 1'b0;
      if (!stall_MEM) break;
      st++;
      if (st > 40) begin
        chk("stall_bound", 32'(st), 32'(exp_st));
        break;
      end
    end
    @(posedge clk); #1;
    chk("stall_cycles", 32'(st), 32'(exp_st));
  endtask

  // Monitor: every visible WB event must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    wb_exp_t e;
    if (!rst && (regwrite_MEM || buserr_MEM || misalign_MEM)) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", {29'd0, regwrite_MEM, buserr_MEM, misalign_MEM}, 32'd0);
      end else begin
        e = wb_q.pop_front();
        chk("wb_regwrite", {31'd0, regwrite_MEM}, {31'd0, e.regwrite});
        chk("wb_buserr",   {31'd0, buserr_MEM},   {31'd0, e.buserr});
        chk("wb_misalign", {31'd0, misalign_MEM}, {31'd0, e.misal});
        if (!e.buserr && !e.misal) begin
          chk("wb_wbsel",    {29'd0, wbsel_MEM}, {29'd0, e.wbsel});
          chk("wb_rd",       {27'd0, rd_MEM},    {27'd0, e.rd});
          chk("wb_aluout",   aluout_MEM,   e.aluout);
          chk("wb_immext",   immext_MEM,   e.immext);
          chk("wb_pcimmaui", pcimmaui_MEM, e.pcimmaui);
          chk("wb_pcnext",   pcnext_MEM,   e.pcnext);
          if (e.chk_rdata) chk("wb_rdata", rdata_MEM, e.rdata);
        end
      end
    end
  end

  // Bus responder: checks each request against the model and answers after the chosen latency.
  initial begin : responder
    bus_exp_t e;
    int k;
    dbus_if.dbus_ready = 1'b0;
    dbus_if.dbus_rdata = 32'd0;
    forever begin
      @(negedge clk);
      dbus_if.dbus_ready = 1'b0;
      dbus_if.dbus_rdata = $urandom;
      if (!rst && dbus_if.dbus_req) begin
        if (bus_q.size() == 0) begin
          chk("bus_unexpected", {31'd0, dbus_if.dbus_req}, 32'd0);
        end else begin
          e = bus_q.pop_front();
          chk("bus_we",   {31'd0, dbus_if.dbus_we}, {31'd0, e.we});
          chk("bus_addr", dbus_if.dbus_addr, e.addr);
          chk("bus_be",   {28'd0, dbus_if.dbus_be}, {28'd0, e.be});
          if (e.we) chk("bus_wdata", dbus_if.dbus_wdata, e.wdata);
          k = 0;
          while (dbus_if.dbus_req && k < 64) begin
            chk("bus_addr_stable", dbus_if.dbus_addr, e.addr);
            if (k == e.lat) begin
              dbus_if.dbus_ready = 1'b1;
              dbus_if.dbus_rdata = e.rdata;
            end
            @(negedge clk);
            dbus_if.dbus_ready = 1'b0;
            dbus_if.dbus_rdata = $urandom;
            k++;
          end
          if (e.lat >= 0) chk("req_cycles", 32'(k), 32'((e.lat >= TO) ? TO : e.lat + 1));
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int kind, lat;
    logic [2:0] sb;
    bus_exp_t b;
    rst = 1'b1;
    regwrite_EX = 1'b0; datawe_EX = 1'b0; wbsel_EX = 3'b000; strb_EX = 3'b000; rd_EX = 5'd0;
    aluout_EX = 32'd0; rdata2_EX = 32'd0; immext_EX = 32'd0; pcimmaui_EX = 32'd0; pcnext_EX = 32'd0;
    #3;
    chk("rst_req",      {31'd0, dbus_if.dbus_req}, 32'd0);
    chk("rst_regwrite", {31'd0, regwrite_MEM}, 32'd0);
    chk("rst_wb_zero",  {31'd0, |{wbsel_MEM, rd_MEM, aluout_MEM, rdata_MEM, immext_MEM, pcimmaui_MEM, pcnext_MEM}}, 32'd0);
    chk("rst_flags",    {30'd0, buserr_MEM, misalign_MEM}, 32'd0);
    chk("rst_stall",    {31'd0, stall_MEM}, 32'd0);
    #19 rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases: ALU op, SB, LB/LBU/LH extension, timeout, misaligned LW.
    issue(1'b1, 1'b0, 3'b000, 3'b000, 5'd5, 32'h0000_1234, 32'h0, 0, 32'h0);
    issue(1'b0, 1'b1, 3'b000, 3'b000, 5'd0, 32'h0000_1003, 32'hAABB_CCDD, 2, 32'h0);
    issue(1'b1, 1'b0, 3'b001, 3'b000, 5'd7, 32'h0000_2001, 32'h0, 0, 32'h0000_F000);
    issue(1'b1, 1'b0, 3'b001, 3'b100, 5'd8, 32'h0000_2001, 32'h0, 0, 32'h0000_F000);
    issue(1'b1, 1'b0, 3'b001, 3'b001, 5'd9, 32'h0000_2002, 32'h0, 1, 32'h8000_0000);
    issue(1'b1, 1'b0, 3'b001, 3'b010, 5'd10, 32'h0000_2000, 32'h0, 10, 32'h1234_5678);
    issue(1'b1, 1'b0, 3'b001, 3'b010, 5'd11, 32'h0000_3002, 32'h0, 1, 32'hCAFE_BABE);
    issue(1'b1, 1'b0, 3'b000, 3'b000, 5'd12, 32'h0000_0042, 32'h0, 0, 32'h0);

    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 2);
      sb   = strb_tab[$urandom_range(0, 7)];
      lat  = $urandom_range(0, 5);
      case (kind)
        0: issue(1'($urandom), 1'b0, alu_wb[$urandom_range(0, 3)], sb, 5'($urandom), $urandom, $urandom, lat, $urandom);
        1: issue(1'($urandom), 1'b0, 3'b001, sb, 5'($urandom), $urandom, $urandom, lat, $urandom);
        default: issue(1'($urandom), 1'b1, 3'b000, sb, 5'($urandom), $urandom, $urandom, lat, $urandom);
      endcase
    end

    // Reset in the middle of a BUSY load: request and WB register must clear at once.
    regwrite_EX = 1'b1; datawe_EX = 1'b0; wbsel_EX = 3'b001; strb_EX = 3'b010; rd_EX = 5'd9;
    aluout_EX = 32'h0000_4000; rdata2_EX = 32'h0; immext_EX = 32'h1111_1111;
    pcimmaui_EX = 32'h2222_2222; pcnext_EX = 32'h3333_3333;
    b.we = 1'b0; b.addr = 32'h0000_4000; b.wdata = 32'h0; b.be = 4'b1111; b.lat = -1; b.rdata = 32'h0;
    bus_q.push_back(b);
    @(negedge clk); #1;
    chk("rst_mid_stall", {31'd0, stall_MEM}, 32'd1);
    @(posedge clk); #1;
    chk("rst_mid_req_before", {31'd0, dbus_if.dbus_req}, 32'd1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_req",     {31'd0, dbus_if.dbus_req}, 32'd0);
    chk("rst_mid_wb_zero", {31'd0, |{regwrite_MEM, wbsel_MEM, rd_MEM, aluout_MEM, rdata_MEM,
                                      immext_MEM, pcimmaui_MEM, pcnext_MEM, buserr_MEM, misalign_MEM}}, 32'd0);
    regwrite_EX = 1'b0; wbsel_EX = 3'b000;
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      chk("req_after_rst", {31'd0, dbus_if.dbus_req}, 32'd0);
    end

    repeat (4) @(negedge clk);
    chk("wb_q_drained",  32'(wb_q.size()), 32'd0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM-side consumer of the EX->MEM pipeline register bundle. Turns load/store control into a request/ready data-bus transaction and freezes the upstream pipeline while the bus is busy.
- Builds byte enables and replicated write data for stores; aligns and sign/zero-extends load data.
- Registers results into the MEM->WB pipeline register.

Parameters:
- BUS_TIMEOUT, 255, max BUSY cycles waiting for dbus_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- regwrite_EX  in  1  register write enable from EX
- datawe_EX  in  1  store
- wbsel_EX  in  3  writeback select; 3'b001 = load
- strb_EX  in  3  funct3 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rd_EX  in  5  destination register
- aluout_EX  in  32  effective address / ALU result
- rdata2_EX  in  32  store data
- immext_EX, pcimmaui_EX, pcnext_EX  in  32 each  passthrough to WB
- dbus_req  out  1  bus request
- dbus_we  out  1  bus write
- dbus_addr  out  32  word address {aluout_EX[31:2],2'b00}
- dbus_wdata  out  32  replicated store data
- dbus_be  out  4  byte enables
- dbus_rdata  in  32  read data, valid with dbus_ready
- dbus_ready  in  1  transaction complete
- stall_MEM  out  1  freeze PC/IF/ID/EX registers
- regwrite_MEM, wbsel_MEM(3), rd_MEM(5), aluout_MEM(32), rdata_MEM(32), immext_MEM, pcimmaui_MEM, pcnext_MEM  out  MEM->WB register
- buserr_MEM  out  1  one-cycle pulse, bus timeout abort
- misalign_MEM  out  1  one-cycle pulse, misaligned access (macro only; tied 0 otherwise)

Behaviour:
- access = datawe_EX | (wbsel_EX==3'b001); off = aluout_EX[1:0].
- Reset (async, rst=1): state IDLE, timeout counter 0, all MEM->WB outputs 0, buserr/misalign 0. dbus_req drops immediately, even mid-transaction. No bus completion is honoured after reset.
- FSM IDLE:
  - no access: WB registers load the EX bundle every cycle (1-cycle latency); stall_MEM=0.
  - access: stall_MEM=1 combinationally; next state BUSY; WB gets a bubble (regwrite_MEM=0).
- FSM BUSY:
  - dbus_req=1; dbus_we/addr/wdata/be are decoded from the held EX inputs and stay stable.
  - stall_MEM = ~dbus_ready.
  - dbus_ready=1: WB registers load the bundle; rdata_MEM gets the extracted load data; state -> IDLE. EX advances on the same edge.
  - Minimum access latency: 2 cycles.
- dbus_ready is ignored when dbus_req=0.
- Timeout counter:
  - increments each BUSY cycle without ready; cleared on entering IDLE.
  - reaching BUSY_TIMEOUT (if nonzero) forces: req low, state IDLE, stall_MEM=0 that cycle, WB bubble with regwrite_MEM=0, buserr_MEM pulse.
  - ready and timeout in the same cycle: ready wins.
- Store encoding:
  - SB: wdata = {4{rdata2[7:0]}}, be = 4'b0001<<off.
  - SH: wdata = {2{rdata2[15:0]}}, be = 4'b0011<<{off[1],1'b0}.
  - SW: wdata = rdata2, be = 4'b1111.
- Load data:
  - LB/LBU: byte dbus_rdata[8*off+:8], sign/zero extended.
  - LH/LHU: half dbus_rdata[16*off[1]+:16], sign/zero extended.
  - LW: full word.
  - Loads drive be = 4'b1111.
- Undefined strb codes: treated as word.
- Non-access instructions never touch the bus; dbus_req=0 in IDLE.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined: a misaligned access (H with off[0]=1, W with off!=0) issues no bus request and stays in IDLE with no stall. WB gets a bubble (regwrite_MEM=0) and misalign_MEM pulses one cycle.
- Undefined: low address bits are truncated per size (H uses off[1], W ignores off), the access is performed normally, and misalign_MEM is tied 0.

Test Plan:
- ADD (regwrite=1, rd=5, aluout=0x1234) in IDLE -> next cycle regwrite_MEM=1, rd_MEM=5, aluout_MEM=0x1234, stall_MEM never high.
- SB addr=0x1003, rdata2=0xAABBCCDD, ready 2 cycles after req -> dbus_be=4'b1000, wdata=0xDDDDDDDD, dbus_addr=0x1000, stall_MEM high exactly 3 cycles, dbus_we=1.
- LB addr=0x2001, dbus_rdata=0x0000F000, ready first BUSY cycle -> rdata_MEM=0xFFFFFFF0; same with LBU -> 0x000000F0; LH addr=0x2002, rdata=0x80000000 -> 0xFFFF8000.
- BUS_TIMEOUT=4, ready never asserted -> req high 4 cycles then low, buserr_MEM 1-cycle pulse, regwrite_MEM=0, stall_MEM released.
- rst asserted in BUSY with req=1 -> dbus_req=0 and all WB outputs 0 immediately; after release with no access, req stays 0.
- MEM_MISALIGN_TRAP_EN defined, LW addr=0x3002 -> dbus_req stays 0, misalign_MEM pulses, regwrite_MEM=0; undefined -> access issued to 0x3000 with be=4'b1111.
